// File: rtl/led_event_blinker.sv
// ---------------------------------------------------------------------------
// led_event_blinker
//
// Turns single-cycle event pulses into LED blinks a person can see. Each
// accepted event gives one ON pulse of ON_CYCLES clocks followed by an OFF
// gap of OFF_CYCLES clocks. Events that arrive while a blink is running are
// counted in a saturating pending counter and played back in order, with no
// idle cycle between back-to-back blinks.
//
// Parameters
//   ON_CYCLES   LED-high duration per blink, in clocks (>= 1)
//   OFF_CYCLES  LED-low gap after each blink, in clocks (>= 1)
//   PEND_W      pending-counter width; up to 2**PEND_W-1 queued events
//
// Ports
//   i_Clk       system clock, rising edge
//   i_Reset     synchronous reset, active-high; discards queued events
//   i_Event     event request; every high cycle counts as one event
//   o_LED       registered LED drive, 1 = on
//   o_Busy      1 while a blink (ON or GAP phase) is in progress
//   o_Pending   queued events not yet started
//   o_Overflow  sticky flag: an event was dropped because the queue was full
// ---------------------------------------------------------------------------
module led_event_blinker #(
    parameter int ON_CYCLES  = 2500000,
    parameter int OFF_CYCLES = 2500000,
    parameter int PEND_W     = 4
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Event,
    output logic              o_LED,
    output logic              o_Busy,
    output logic [PEND_W-1:0] o_Pending,
    output logic              o_Overflow
);

    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TIMER_W = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

    // The timer holds "cycles remaining after this one", so a phase of N
    // cycles is loaded with N-1 and ends when the timer reads zero.
    localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0]  PEND_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [PEND_W-1:0]   pend_q,  pend_d;
    logic                ovf_q,   ovf_d;
    logic                led_q,   led_d;

    logic                start_ok;
    logic                start;
    logic                queue_nonempty;
    logic                take_queue;
    logic                take_direct;
    logic                ev_to_queue;

    // -----------------------------------------------------------------------
    // Next-state, timer, and queue logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        pend_d         = pend_q;
        ovf_d          = ovf_q;
        start_ok       = 1'b0;
        queue_nonempty = (pend_q != '0);

        case (state_q)
            ST_IDLE: begin
                start_ok = 1'b1;
            end

            ST_ON: begin
                if (timer_q == '0) begin
                    state_d = ST_GAP;
                    timer_d = OFF_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            ST_GAP: begin
                if (timer_q == '0) begin
                    // Last gap cycle: either chain straight into the next
                    // blink (handled below) or fall back to idle.
                    start_ok = 1'b1;
                    state_d  = ST_IDLE;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

        start = start_ok & (i_Event | queue_nonempty);
        if (start) begin
            state_d = ST_ON;
            timer_d = ON_LOAD;
        end

        // Queued events are served first; a concurrent event is consumed
        // directly only when nothing is waiting, otherwise it joins the queue.
        take_queue  = start & queue_nonempty;
        take_direct = start & ~queue_nonempty;
        ev_to_queue = i_Event & ~take_direct;

        if (ev_to_queue && !take_queue) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (!ev_to_queue && take_queue) begin
            pend_d = pend_q - 1'b1;
        end

        led_d = (state_d == ST_ON);
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            led_q   <= led_d;
        end
    end

    assign o_LED      = led_q;
    assign o_Busy     = (state_q != ST_IDLE);
    assign o_Pending  = pend_q;
    assign o_Overflow = ovf_q;

endmodule

// File: tb/tb_led_event_blinker.sv
// ---------------------------------------------------------------------------
// tb_led_event_blinker
//
// Directed scenarios on a small configuration (ON=4, OFF=3, PEND_W=2).
// Cycle k of a scenario spans posedge k to posedge k+1; inputs for cycle k
// are driven at its negedge and outputs are observed at negedges.
// A blink-level model (remaining-cycles count plus pending count) is checked
// against the DUT every cycle after reset; literal expectations pin the
// model on the documented scenarios.
// ---------------------------------------------------------------------------
module tb_led_event_blinker;

    localparam int ON_C   = 4;
    localparam int OFF_C  = 3;
    localparam int PW     = 2;
    localparam int PMAX   = (1 << PW) - 1;
    localparam int LEN    = 40;

    logic          i_Clk = 1'b0;
    logic          i_Reset = 1'b1;
    logic          i_Event = 1'b0;
    logic          o_LED;
    logic          o_Busy;
    logic [PW-1:0] o_Pending;
    logic          o_Overflow;

    int checks = 0;
    int errors = 0;

    led_event_blinker #(
        .ON_CYCLES (ON_C),
        .OFF_CYCLES(OFF_C),
        .PEND_W    (PW)
    ) dut (
        .i_Clk     (i_Clk),
        .i_Reset   (i_Reset),
        .i_Event   (i_Event),
        .o_LED     (o_LED),
        .o_Busy    (o_Busy),
        .o_Pending (o_Pending),
        .o_Overflow(o_Overflow)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_rem: cycles left in the current blink+gap; LED is on while more than
    // OFF_C cycles remain. A new blink may begin when at most one remains.
    int m_rem  = 0;
    int m_pend = 0;
    bit m_ovf  = 0;
    bit m_valid = 0;

    always @(posedge i_Clk) begin
        bit can_start, from_q, direct, ev_left;
        if (i_Reset) begin
            m_rem = 0; m_pend = 0; m_ovf = 0; m_valid = 1;
        end else if (m_valid) begin
            can_start = (m_rem <= 1) && (i_Event || m_pend > 0);
            from_q    = can_start && (m_pend > 0);
            direct    = can_start && !from_q;
            ev_left   = i_Event && !direct;
            if (ev_left && !from_q) begin
                if (m_pend == PMAX) m_ovf = 1;
                else m_pend++;
            end else if (!ev_left && from_q) begin
                m_pend--;
            end
            if (can_start) m_rem = ON_C + OFF_C;
            else if (m_rem > 0) m_rem--;
        end
    end

    always @(negedge i_Clk) begin
        if (m_valid) begin
            check("model_led",  {7'd0, o_LED},      {7'd0, m_rem > OFF_C});
            check("model_busy", {7'd0, o_Busy},     {7'd0, m_rem > 0});
            check("model_pend", 8'(o_Pending),      8'(m_pend));
            check("model_ovf",  {7'd0, o_Overflow}, {7'd0, m_ovf});
        end
    end

    // ---------------- directed scenarios ----------------
    logic       led_log  [0:LEN-1];
    logic       busy_log [0:LEN-1];
    logic [PW-1:0] pend_log [0:LEN-1];
    logic       ovf_log  [0:LEN-1];

    task automatic run(input logic [63:0] ev_mask, input logic [63:0] rst_mask);
        for (int t = 0; t < LEN; t++) begin
            @(negedge i_Clk);
            led_log[t]  = o_LED;
            busy_log[t] = o_Busy;
            pend_log[t] = o_Pending;
            ovf_log[t]  = o_Overflow;
            i_Event = ev_mask[t];
            i_Reset = rst_mask[t];
        end
    endtask

    function automatic int blinks();
        int n = 0;
        for (int t = 1; t < LEN; t++)
            if (led_log[t] === 1'b1 && led_log[t-1] === 1'b0) n++;
        return n;
    endfunction

    function automatic logic [63:0] bits(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int t = lo; t <= hi; t++) m[t] = 1'b1;
        return m;
    endfunction

    logic [63:0] rst0;

    initial begin
        rst0 = bits(0, 2);

        // Single pulse at 10
        run(bits(10, 10), rst0);
        check("t1_reset_led",  {7'd0, led_log[3]},  8'd0);
        check("t1_reset_busy", {7'd0, busy_log[3]}, 8'd0);
        check("t1_reset_pend", 8'(pend_log[3]),     8'd0);
        check("t1_reset_ovf",  {7'd0, ovf_log[3]},  8'd0);
        check("t1_led10", {7'd0, led_log[10]}, 8'd0);
        for (int t = 11; t <= 14; t++) check("t1_led_on", {7'd0, led_log[t]}, 8'd1);
        for (int t = 15; t <= 17; t++) check("t1_led_gap", {7'd0, led_log[t]}, 8'd0);
        check("t1_busy17", {7'd0, busy_log[17]}, 8'd1);
        check("t1_busy18", {7'd0, busy_log[18]}, 8'd0);
        check("t1_pend12", 8'(pend_log[12]), 8'd0);
        check("t1_blinks", 8'(blinks()), 8'd1);

        // Pulses at 10,11,12
        run(bits(10, 12), rst0);
        check("t2_pend13", 8'(pend_log[13]), 8'd2);
        check("t2_led14",  {7'd0, led_log[14]}, 8'd1);
        check("t2_led17",  {7'd0, led_log[17]}, 8'd0);
        check("t2_led18",  {7'd0, led_log[18]}, 8'd1);
        check("t2_led21",  {7'd0, led_log[21]}, 8'd1);
        check("t2_led22",  {7'd0, led_log[22]}, 8'd0);
        check("t2_led25",  {7'd0, led_log[25]}, 8'd1);
        check("t2_led28",  {7'd0, led_log[28]}, 8'd1);
        check("t2_led29",  {7'd0, led_log[29]}, 8'd0);
        check("t2_pend17", 8'(pend_log[17]), 8'd2);
        check("t2_pend18", 8'(pend_log[18]), 8'd1);
        check("t2_pend25", 8'(pend_log[25]), 8'd0);
        check("t2_blinks", 8'(blinks()), 8'd3);

        // Pulses every cycle 10-14: queue fills, one dropped
        run(bits(10, 14), rst0);
        check("t3_pend14", 8'(pend_log[14]), 8'd3);
        check("t3_ovf14",  {7'd0, ovf_log[14]}, 8'd0);
        check("t3_ovf15",  {7'd0, ovf_log[15]}, 8'd1);
        check("t3_pend15", 8'(pend_log[15]), 8'd3);
        check("t3_ovf39",  {7'd0, ovf_log[39]}, 8'd1);
        check("t3_blinks", 8'(blinks()), 8'd4);

        // Pulses at 10 and 17 (last gap cycle, queue empty)
        run(bits(10, 10) | bits(17, 17), rst0);
        for (int t = 18; t <= 21; t++) check("t4_led_on2", {7'd0, led_log[t]}, 8'd1);
        for (int t = 11; t <= 24; t++) check("t4_busy", {7'd0, busy_log[t]}, 8'd1);
        check("t4_busy25", {7'd0, busy_log[25]}, 8'd0);
        check("t4_pend18", 8'(pend_log[18]), 8'd0);
        check("t4_blinks", 8'(blinks()), 8'd2);

        // Pulses 10,11,12 then reset at 13
        run(bits(10, 12), rst0 | bits(13, 13));
        check("t5_pend13", 8'(pend_log[13]), 8'd2);
        check("t5_led14",  {7'd0, led_log[14]}, 8'd0);
        check("t5_pend14", 8'(pend_log[14]), 8'd0);
        check("t5_busy14", {7'd0, busy_log[14]}, 8'd0);
        check("t5_ovf14",  {7'd0, ovf_log[14]}, 8'd0);
        check("t5_blinks", 8'(blinks()), 8'd1);

        // Event held with queue full, then reset while the event is still high
        run(bits(10, 26), rst0 | bits(26, 26));
        check("t6_pend25", 8'(pend_log[25]), 8'd3);
        check("t6_ovf26",  {7'd0, ovf_log[26]}, 8'd1);
        check("t6_ovf27",  {7'd0, ovf_log[27]}, 8'd0);
        check("t6_pend27", 8'(pend_log[27]), 8'd0);
        check("t6_led27",  {7'd0, led_log[27]}, 8'd0);
        check("t6_blinks", 8'(blinks()), 8'd3);

        @(negedge i_Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
